// File: rtl/rr_arb8_dec.sv
// rr_arb8_dec: 8-requester round-robin arbiter with a registered grant index
// and its one-hot decode. A grant is held until the owner pulses done or drops
// its request, then passes directly to the next pending requester in
// round-robin order.
// Optional feature macro: RR_ARB_TIMEOUT_EN. When defined, a grant held for
// HOLD_MAX cycles while another requester waits is force-released and timeout
// pulses for one cycle. When undefined, timeout is tied low.
//
// Handshake: req is level-sensitive. Requester i owns the resource while
// gnt_vld=1 and gnt_idx=i. It releases ownership by pulsing done or by
// deasserting req[i]. done is ignored while gnt_vld=0.
module rr_arb8_dec #(
  parameter int HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic       gnt_vld,
  output logic [2:0] gnt_idx,
  output logic [7:0] gnt,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [2:0] ptr;

  // A hold limit below 2 cannot describe a meaningful grant window.
  if (HOLD_MAX < 2) begin : g_bad_hold_max
    $error("rr_arb8_dec: HOLD_MAX must be >= 2");
  end

  // Scan r starting at p and wrapping modulo 8. The result is {found, index}.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'd0;
    for (int k = 7; k >= 0; k--) begin
      idx = p + 3'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  logic [7:0] others;
  logic [3:0] pick_req;
  logic [3:0] pick_oth;
  logic       owner_rel;
  logic       force_rel;
  logic       grant_idle;
  logic       grant_other;
  logic       any_rel;

  assign others      = req & ~(8'b1 << gnt_idx);
  assign pick_req    = rr_pick(req, ptr);
  assign pick_oth    = rr_pick(others, ptr);
  assign owner_rel   = done | ~req[gnt_idx];
  assign any_rel     = owner_rel | force_rel;
  assign grant_idle  = (state == IDLE) && pick_req[3];
  assign grant_other = (state == GRANT) && any_rel && pick_oth[3];

`ifdef RR_ARB_TIMEOUT_EN
  localparam int CW = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

  logic [CW-1:0] hold_cnt;

  assign force_rel = (state == GRANT) && (hold_cnt == HOLD_LAST) && (others != 8'h00);

  // Hold-time counter. It restarts on every new grant and saturates while the owner is alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= force_rel & ~owner_rel;
      if (grant_idle || grant_other) begin
        hold_cnt <= '0;
      end else if (state == GRANT && hold_cnt != HOLD_LAST) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end
`else
  assign force_rel = 1'b0;
  assign timeout   = 1'b0;
`endif

  // Arbitration FSM. The grant index, its decode and the valid flag are all registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= 3'd0;
      gnt_vld <= 1'b0;
      gnt_idx <= 3'd0;
      gnt     <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (grant_idle) begin
            state   <= GRANT;
            gnt_vld <= 1'b1;
            gnt_idx <= pick_req[2:0];
            gnt     <= 8'b1 << pick_req[2:0];
            ptr     <= pick_req[2:0] + 3'd1;
          end
        end
        GRANT: begin
          if (grant_other) begin
            gnt_idx <= pick_oth[2:0];
            gnt     <= 8'b1 << pick_oth[2:0];
            ptr     <= pick_oth[2:0] + 3'd1;
          end else if (any_rel) begin
            state   <= IDLE;
            gnt_vld <= 1'b0;
            gnt     <= 8'h00;
          end
        end
        default: begin
          state   <= IDLE;
          gnt_vld <= 1'b0;
          gnt     <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arb8_dec.sv
// tb_rr_arb8_dec: directed, table-driven bench for the round-robin arbiter.
module tb_rr_arb8_dec;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic       gnt_vld;
  logic [2:0] gnt_idx;
  logic [7:0] gnt;
  logic       timeout;

  int checks;
  int failures;

  rr_arb8_dec #(.HOLD_MAX(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx),
    .gnt     (gnt),
    .timeout (timeout)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic       done;
    logic       vld;
    logic [2:0] idx;
    logic [7:0] gnt;
  } vec_t;

  vec_t vecs[20];

  // Advance one clock and settle just past the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string name, input logic vld, input logic [2:0] idx,
                         input logic [7:0] g, input logic to);
    chk({name, ".gnt_vld"}, 32'(gnt_vld), 32'(vld));
    if (vld) chk({name, ".gnt_idx"}, 32'(gnt_idx), 32'(idx));
    chk({name, ".gnt"}, 32'(gnt), 32'(g));
    chk({name, ".timeout"}, 32'(timeout), 32'(to));
  endtask

  initial begin
    int cur;
    checks   = 0;
    failures = 0;

    // Rows are in sequence. Each row is applied for one cycle, starting right after reset.
    vecs[0]  = '{8'hFF, 1'b0, 1'b1, 3'd0, 8'h01};
    vecs[1]  = '{8'hFF, 1'b0, 1'b1, 3'd0, 8'h01};
    vecs[2]  = '{8'hFF, 1'b1, 1'b1, 3'd1, 8'h02};
    vecs[3]  = '{8'hFF, 1'b0, 1'b1, 3'd1, 8'h02};
    vecs[4]  = '{8'h04, 1'b0, 1'b1, 3'd2, 8'h04};
    vecs[5]  = '{8'h04, 1'b1, 1'b0, 3'd0, 8'h00};
    vecs[6]  = '{8'h04, 1'b0, 1'b1, 3'd2, 8'h04};
    vecs[7]  = '{8'h00, 1'b0, 1'b0, 3'd0, 8'h00};
    vecs[8]  = '{8'h00, 1'b1, 1'b0, 3'd0, 8'h00};
    vecs[9]  = '{8'hC0, 1'b0, 1'b1, 3'd6, 8'h40};
    vecs[10] = '{8'h21, 1'b1, 1'b1, 3'd0, 8'h01};
    vecs[11] = '{8'h21, 1'b1, 1'b1, 3'd5, 8'h20};
    vecs[12] = '{8'h21, 1'b0, 1'b1, 3'd5, 8'h20};
    vecs[13] = '{8'hFF, 1'b0, 1'b1, 3'd5, 8'h20};
    vecs[14] = '{8'h08, 1'b0, 1'b1, 3'd3, 8'h08};
    vecs[15] = '{8'h00, 1'b0, 1'b0, 3'd0, 8'h00};
    vecs[16] = '{8'h08, 1'b0, 1'b1, 3'd3, 8'h08};
    vecs[17] = '{8'h08, 1'b1, 1'b0, 3'd0, 8'h00};
    vecs[18] = '{8'h08, 1'b0, 1'b1, 3'd3, 8'h08};
    vecs[19] = '{8'h10, 1'b0, 1'b1, 3'd4, 8'h10};

    // Reset with every requester asserting: no grant may appear.
    rst_n = 1'b0;
    req   = 8'hFF;
    done  = 1'b0;
    tick();
    tick();
    chk_out("reset", 1'b0, 3'd0, 8'h00, 1'b0);
    chk("reset.gnt_idx", 32'(gnt_idx), 32'd0);
    rst_n = 1'b1;

    // Table-driven sequence: first grant, release, drop, idle, wrap/skip, regrant.
    for (int i = 0; i < 20; i++) begin
      req  = vecs[i].req;
      done = vecs[i].done;
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].vld, vecs[i].idx, vecs[i].gnt, 1'b0);
    end

    // Asynchronous reset between edges while requester 4 owns the grant.
    done = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 3'd0, 8'h00, 1'b0);
    chk("async_rst.gnt_idx", 32'(gnt_idx), 32'd0);

    // Rotation: every requester asserts, and done is pulsed on every third cycle.
    req = 8'hFF;
    tick();
    rst_n = 1'b1;
    tick();
    chk_out("rot.first", 1'b1, 3'd0, 8'h01, 1'b0);
    cur = 0;
    for (int g = 0; g < 8; g++) begin
      for (int c = 0; c < 3; c++) begin
        done = (c == 2);
        tick();
        if (c == 2) cur = (cur + 1) % 8;
        chk_out($sformatf("rot%0d_%0d", g, c), 1'b1, 3'(cur), 8'(1 << cur), 1'b0);
      end
    end
    chk("rot.final_idx", 32'(gnt_idx), 32'd0);
    done = 1'b0;

    // Hold behaviour with two requesters and no done.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    req = 8'h03;
    tick();
    for (int c = 0; c < 4; c++) begin
      chk_out($sformatf("hold0_%0d", c), 1'b1, 3'd0, 8'h01, 1'b0);
      tick();
    end
`ifdef RR_ARB_TIMEOUT_EN
    chk_out("timeout.fire", 1'b1, 3'd1, 8'h02, 1'b1);
    tick();
    chk_out("timeout.after", 1'b1, 3'd1, 8'h02, 1'b0);
    req = 8'h01;
    tick();
    chk_out("timeout.solo", 1'b1, 3'd0, 8'h01, 1'b0);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk_out($sformatf("solo_hold%0d", c), 1'b1, 3'd0, 8'h01, 1'b0);
    end
`else
    for (int c = 0; c < 6; c++) begin
      chk_out($sformatf("nolimit%0d", c), 1'b1, 3'd0, 8'h01, 1'b0);
      tick();
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
